// File: rtl/la_mul_pkg.sv
// la_mul_pkg: shared op encoding, FSM states and request layout for the EXE multiplier requester.
`default_nettype none

package la_mul_pkg;

  localparam int XLEN  = 32;
  localparam int OP_W  = 3;
  localparam int REQ_W = OP_W + 2 * XLEN;
  localparam int RES_W = XLEN;

  localparam logic [OP_W-1:0] OP_MUL_W   = 3'b001;
  localparam logic [OP_W-1:0] OP_MULH_W  = 3'b010;
  localparam logic [OP_W-1:0] OP_MULH_WU = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
  } req_t;

  // Keeps only the lowest set bit so a malformed multi-hot op still selects one operation.
  function automatic logic [OP_W-1:0] op_lowest(input logic [OP_W-1:0] op);
    logic [OP_W-1:0] r;
    r = op & (~op + OP_W'(1));
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_wdog.sv
// mul_wdog: completion watchdog counter with clear/enable and a terminal-count expire flag.
`default_nettype none

module mul_wdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en & (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/exe_mul_issue.sv
// exe_mul_issue: issues MUL.W/MULH.W/MULH.WU to the multiplier and holds the result for MEM.
`default_nettype none

module exe_mul_issue
  import la_mul_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [XLEN-1:0]   req_src1,
  input  logic [XLEN-1:0]   req_src2,
  input  logic              flush,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic              mul_start,
  output logic [OP_W-1:0]   mul_op,
  output logic [XLEN-1:0]   mul_src1,
  output logic [XLEN-1:0]   mul_src2,
  input  logic              mul_done,
  input  logic [RES_W-1:0]  mul_result,
  output logic              err_timeout,
  output logic              err_proto
);

  state_t            state_q, state_d;
  req_t              req_q, req_d;
  logic [RES_W-1:0]  res_data_q, res_data_d;
  logic              res_valid_q, res_valid_d;
  logic              mul_start_q, mul_start_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_proto_q, err_proto_d;

  logic              req_ready_w;
  logic              accept;
  logic              take;
  logic [OP_W-1:0]   op_sel;
  logic              wdog_expire;

  mul_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (state_q == ST_ISSUE),
    .en     ((state_q == ST_WAIT) || (state_q == ST_DRAIN)),
    .expire (wdog_expire)
  );

  assign req_ready_w = ~reset & ~flush &
                       ((state_q == ST_IDLE) | ((state_q == ST_DONE) & res_ready));
  assign accept      = req_valid & req_ready_w;
  assign op_sel      = op_lowest(req_op);

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    res_data_d    = res_data_q;
    mul_start_d   = 1'b0;
    err_timeout_d = err_timeout_q;
    err_proto_d   = err_proto_q;
    take          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mul_done) err_proto_d = 1'b1;
        take = accept;
      end
      // The start pulse is already out in ISSUE, so a flush must still wait for its done.
      ST_ISSUE, ST_WAIT: begin
        if (flush) begin
          state_d = mul_done ? ST_IDLE : ST_DRAIN;
        end else if (mul_done) begin
          res_data_d = mul_result;
          state_d    = ST_DONE;
        end else if (wdog_expire) begin
          err_timeout_d = 1'b1;
          res_data_d    = '0;
          state_d       = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (mul_done) begin
          state_d = ST_IDLE;
        end else if (wdog_expire) begin
          err_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (mul_done) err_proto_d = 1'b1;
        if (flush || res_ready) state_d = ST_IDLE;
        take = accept;
      end
      default: state_d = ST_IDLE;
    endcase

    if (take) begin
      req_d.op   = op_sel;
      req_d.src1 = req_src1;
      req_d.src2 = req_src2;
      if (op_sel == '0) begin
        err_proto_d = 1'b1;
        res_data_d  = '0;
        state_d     = ST_DONE;
      end else begin
        mul_start_d = 1'b1;
        state_d     = ST_ISSUE;
      end
    end

    res_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      req_q         <= '0;
      res_data_q    <= '0;
      res_valid_q   <= 1'b0;
      mul_start_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      err_proto_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      res_data_q    <= res_data_d;
      res_valid_q   <= res_valid_d;
      mul_start_q   <= mul_start_d;
      err_timeout_q <= err_timeout_d;
      err_proto_q   <= err_proto_d;
    end
  end

  assign req_ready   = req_ready_w;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign mul_start   = mul_start_q;
  assign mul_op      = req_q.op;
  assign mul_src1    = req_q.src1;
  assign mul_src2    = req_q.src2;
  assign err_timeout = err_timeout_q;
  assign err_proto   = err_proto_q;

endmodule

`default_nettype wire

// File: tb/tb_exe_mul_issue.sv
// tb_exe_mul_issue: directed bench with a behavioural multiplier of configurable latency.
`default_nettype none

module tb_exe_mul_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        flush;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        mul_start;
  logic [2:0]  mul_op;
  logic [31:0] mul_src1;
  logic [31:0] mul_src2;
  logic        mul_done;
  logic [31:0] mul_result;
  logic        err_timeout;
  logic        err_proto;

  int errors = 0;
  int checks = 0;
  int lat    = 3;
  bit hang   = 1'b0;
  int pend   = 0;

  exe_mul_issue #(.TIMEOUT(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_src1    (req_src1),
    .req_src2    (req_src2),
    .flush       (flush),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .mul_start   (mul_start),
    .mul_op      (mul_op),
    .mul_src1    (mul_src1),
    .mul_src2    (mul_src2),
    .mul_done    (mul_done),
    .mul_result  (mul_result),
    .err_timeout (err_timeout),
    .err_proto   (err_proto)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mul_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] ps;
    logic [63:0]        pu;
    ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    pu = {32'b0, a} * {32'b0, b};
    case (op)
      3'b001:  return pu[31:0];
      3'b010:  return ps[63:32];
      3'b100:  return pu[63:32];
      default: return 32'h0;
    endcase
  endfunction

  // Multiplier model: done pulses exactly lat cycles after the start cycle.
  always @(negedge clk) begin
    mul_done = 1'b0;
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        mul_done   = 1'b1;
        mul_result = mul_model(mul_op, mul_src1, mul_src2);
      end
    end
    if (mul_start && !hang) pend = lat;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input string tag);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    #1;
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  // Called in the ISSUE cycle; checks start, latency to res_valid, data, then consumes.
  task automatic wait_result(input string tag, input int exp_lat, input logic [31:0] exp_data);
    int n = 0;
    chk({tag, "_start"}, 32'(mul_start), 32'd1);
    while (!res_valid && n < 30) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_data"}, res_data, exp_data);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk({tag, "_drop"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=hung expected=finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int n;
    reset = 1'b1; req_valid = 1'b0; req_op = 3'b0; req_src1 = 32'h0; req_src2 = 32'h0;
    flush = 1'b0; res_ready = 1'b0; mul_done = 1'b0; mul_result = 32'h0;
    step();
    step();
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_mul_start", 32'(mul_start), 32'd0);
    chk("rst_res_data", res_data, 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_errs", {30'b0, err_timeout, err_proto}, 32'd0);
    reset = 1'b0;
    step();

    // 1: MUL.W 7 x -3
    send(3'b001, 32'd7, 32'hFFFF_FFFD, "t1");
    chk("t1_src1", mul_src1, 32'd7);
    wait_result("t1", 4, 32'hFFFF_FFEB);

    // 2: high-word variants, multi-hot op and zero op
    send(3'b010, 32'h8000_0000, 32'h8000_0000, "t2a");
    wait_result("t2a", 4, 32'h4000_0000);
    send(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "t2b");
    wait_result("t2b", 4, 32'hFFFF_FFFE);
    send(3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "t2c");
    chk("t2c_op", 32'(mul_op), 32'd2);
    wait_result("t2c", 4, 32'h0);
    chk("t2_proto_clear", 32'(err_proto), 32'd0);
    send(3'b001, 32'd5, 32'd5, "t2d");
    wait_result("t2d", 4, 32'd25);
    send(3'b000, 32'd5, 32'd6, "t2z");
    chk("t2z_start", 32'(mul_start), 32'd0);
    chk("t2z_valid", 32'(res_valid), 32'd1);
    chk("t2z_data", res_data, 32'h0);
    chk("t2z_proto", 32'(err_proto), 32'd1);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    // 3: downstream stall, then back-to-back accept
    send(3'b001, 32'd6, 32'd7, "t3a");
    n = 0;
    while (!res_valid && n < 30) begin step(); n++; end
    chk("t3a_data", res_data, 32'd42);
    req_valid = 1'b1; req_op = 3'b100; req_src1 = 32'h0001_0000; req_src2 = 32'h0001_0000;
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_ready", 32'(req_ready), 32'd0);
      chk("t3_stall_data", res_data, 32'd42);
      step();
    end
    res_ready = 1'b1;
    #1;
    chk("t3_b2b_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    res_ready = 1'b0;
    chk("t3_b2b_op", 32'(mul_op), 32'd4);
    chk("t3_b2b_valid", 32'(res_valid), 32'd0);
    wait_result("t3b", 4, 32'd1);

    // 4: flush in IDLE blocks accept; flush in WAIT drains
    req_valid = 1'b1; req_op = 3'b001; req_src1 = 32'd9; req_src2 = 32'd9; flush = 1'b1;
    #1;
    chk("t4_idle_flush_ready", 32'(req_ready), 32'd0);
    step();
    flush = 1'b0;
    req_valid = 1'b0;
    chk("t4_idle_flush_start", 32'(mul_start), 32'd0);
    send(3'b001, 32'd100, 32'd2, "t4a");
    chk("t4a_start", 32'(mul_start), 32'd1);
    step();
    flush = 1'b1;
    #1;
    chk("t4_wait_flush_ready", 32'(req_ready), 32'd0);
    step();
    flush = 1'b0;
    req_valid = 1'b1; req_op = 3'b001; req_src1 = 32'd3; req_src2 = 32'd5;
    n = 0;
    while (!req_ready && n < 10) begin
      chk("t4_drain_novalid", 32'(res_valid), 32'd0);
      step();
      n++;
    end
    chk("t4_drain_cycles", 32'(n), 32'd2);
    step();
    req_valid = 1'b0;
    wait_result("t4b", 4, 32'd15);

    // 5: watchdog with a multiplier that never completes
    hang = 1'b1;
    send(3'b001, 32'd2, 32'd2, "t5");
    repeat (8) step();
    chk("t5_pre_timeout", 32'(err_timeout), 32'd0);
    chk("t5_pre_valid", 32'(res_valid), 32'd0);
    step();
    chk("t5_timeout", 32'(err_timeout), 32'd1);
    chk("t5_valid", 32'(res_valid), 32'd1);
    chk("t5_data", res_data, 32'h0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    hang = 1'b0;

    // 6: async reset in WAIT, then a stray done in IDLE
    send(3'b001, 32'd9, 32'd9, "t6");
    step();
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_start", 32'(mul_start), 32'd0);
    chk("t6_rst_op", 32'(mul_op), 32'd0);
    chk("t6_rst_src1", mul_src1, 32'h0);
    chk("t6_rst_valid", 32'(res_valid), 32'd0);
    chk("t6_rst_timeout", 32'(err_timeout), 32'd0);
    chk("t6_rst_proto", 32'(err_proto), 32'd0);
    reset = 1'b0;
    n = 0;
    while (!mul_done && n < 10) begin step(); n++; end
    chk("t6_done_seen", 32'(mul_done), 32'd1);
    chk("t6_proto", 32'(err_proto), 32'd1);
    chk("t6_no_valid", 32'(res_valid), 32'd0);
    step();
    chk("t6_no_valid_after", 32'(res_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
